seg_scan: RTL and testbench

Time-multiplexed scanner for an 8-digit common-anode seven-segment display, sitting directly upstream of the hex-to-segment decoder. It holds a captured 32-bit display word and rotates through the digits at a divided refresh rate. Each step presents one 4-bit nibble to the decoder and drives the matching active-low anode and decimal point. A short all-off blanking window on every digit change prevents ghosting, and optional leading-zero suppression is supported.

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan.sv | 123 ++++++++++++
 tb/tb_seg_scan.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus bundle between a display-word source and the seg_scan digit scanner.
// The master drives the capture side; the slave (scanner) drives the decoder/anode side.
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic                  load_i;
  logic [4*DIGITS-1:0]   data_i;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     en_i;
  logic                  lz_en_i;
  logic [3:0]            hex_o;
  logic                  dp_o;
  logic [DIGITS-1:0]     an_o;

  modport master (
    output load_i, data_i, dp_i, en_i, lz_en_i,
    input  hex_o, dp_o, an_o
  );

  modport slave (
    input  load_i, data_i, dp_i, en_i, lz_en_i,
    output hex_o, dp_o, an_o
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode seven-segment scanner with per-slot
// blanking, decimal points, digit enables and leading-zero suppression.
module seg_scan #(
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLANK_CYC - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_idx;
  logic [BW-1:0]       r_bcnt, w_bcnt_nxt;
  logic [4*DIGITS-1:0] r_sh_data;
  logic [DIGITS-1:0]   r_sh_dp, r_sh_en;
  logic                r_show;
  logic [3:0]          r_hex;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an, w_an_nxt;

  logic                w_tick;
  logic [IW-1:0]       w_nidx;
  logic [DIGITS-1:0]   w_tail_zero;
  logic                w_sup;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_nidx = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;

  // w_tail_zero[i]: nibbles i..DIGITS-1 of the shadow word are all zero.
  always_comb begin
    logic v_z;
    w_tail_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v_z = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        v_z = v_z & (r_sh_data[4*j +: 4] == 4'h0);
      end
      w_tail_zero[i] = v_z;
    end
  end

  assign w_sup = bus.lz_en_i & (w_nidx != '0) & w_tail_zero[w_nidx];

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_an_nxt    = r_an;
    if (w_tick) begin
      w_state_nxt = S_BLANK;
      w_bcnt_nxt  = '0;
      w_an_nxt    = '1;
    end else begin
      case (r_state)
        S_BLANK: begin
          if (r_bcnt == BCNT_MAX) begin
            w_an_nxt    = r_show ? ~(DIGITS'(1) << r_idx) : '1;
            w_state_nxt = S_DRIVE;
          end else begin
            w_bcnt_nxt = r_bcnt + 1'b1;
          end
        end
        S_DRIVE: ;
        default: w_state_nxt = S_BLANK;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; that is what makes a load on a tick edge affect only the following slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BLANK;
      r_bcnt  <= '0;
      r_an    <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_an    <= w_an_nxt;
    end
  end

  // NOTE: the shadow registers are reset too, so a mid-slot reset drops the display word and leaves all digits dark until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh_data <= '0;
      r_sh_dp   <= '0;
      r_sh_en   <= '0;
      r_show    <= 1'b0;
      r_hex     <= 4'h0;
      r_dp      <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (bus.load_i) begin
        r_sh_data <= bus.data_i;
        r_sh_dp   <= bus.dp_i;
        r_sh_en   <= bus.en_i;
      end
      if (w_tick) begin
        r_idx  <= w_nidx;
        r_hex  <= r_sh_data[4*w_nidx +: 4];
        r_dp   <= ~r_sh_dp[w_nidx];
        r_show <= r_sh_en[w_nidx] & ~w_sup;
      end
    end
  end

  assign bus.hex_o = r_hex;
  assign bus.dp_o  = r_dp;
  assign bus.an_o  = r_an;
endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a 4-digit fast-refresh instance for function,
// and an 8-digit instance for rotation period and index wrap.
module tb_seg_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst8_n;
  seg_scan_if #(.DIGITS(4)) b4();
  seg_scan_if #(.DIGITS(8)) b8();

  seg_scan #(.DIGITS(4), .REFRESH_DIV(6), .BLANK_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave)
  );
  seg_scan #(.DIGITS(8), .REFRESH_DIV(10), .BLANK_CYC(2)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .bus(b8.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Prescaler/digit-index timing model of the 4-digit instance.
  int m_cnt = 0;
  int m_idx = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= 0;
      m_idx <= 0;
    end else if (m_cnt == 5) begin
      m_cnt <= 0;
      m_idx <= (m_idx + 1) % 4;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
  } exp_t;
  exp_t sb_q[$];

  task automatic expect_lit(input logic [3:0] an, input logic [3:0] hex, input logic dp);
    exp_t e;
    e.an = an; e.hex = hex; e.dp = dp;
    sb_q.push_back(e);
  endtask

  // Monitor: every anode falling edge is a presented output.
  logic [3:0] mon_prev = 4'hF;
  int         lit_len  = 0;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (mon_prev == 4'hF && b4.an_o != 4'hF) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_lit: an_o=%b with nothing expected", b4.an_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("lit_an", 32'(b4.an_o), 32'(mon_e.an));
        check("lit_hex", 32'(b4.hex_o), 32'(mon_e.hex));
        check("lit_dp", 32'(b4.dp_o), 32'(mon_e.dp));
        check("lit_latency", 32'(m_cnt), 32'd2);
      end
      lit_len = 1;
    end else if (b4.an_o != 4'hF) begin
      lit_len++;
    end else if (mon_prev != 4'hF && rst_n) begin
      check("lit_len", 32'(lit_len), 32'd4);
    end
    mon_prev = b4.an_o;
  end

  always @(negedge clk) begin
    assert ($countones(~b4.an_o) <= 1) else begin
      n_err++;
      $error("more than one anode low on 4-digit instance: %b", b4.an_o);
    end
    assert ($countones(~b8.an_o) <= 1) else begin
      n_err++;
      $error("more than one anode low on 8-digit instance: %b", b8.an_o);
    end
  end

  task automatic wait_point(input int idx, input int cnt);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_idx == idx && m_cnt == cnt) && k < 200);
    if (k >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL wait_point: idx %0d cnt %0d not reached", idx, cnt);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp, input logic lz);
    b4.data_i  = d;
    b4.en_i    = en;
    b4.dp_i    = dp;
    b4.lz_en_i = lz;
    b4.load_i  = 1'b1;
    @(negedge clk);
    b4.load_i  = 1'b0;
  endtask

  task automatic check_dark(input string name);
    check({name, "_an"}, 32'(b4.an_o), 32'hF);
    check({name, "_hex"}, 32'(b4.hex_o), 32'h0);
    check({name, "_dp"}, 32'(b4.dp_o), 32'h1);
  endtask

  logic done8 = 1'b0;

  initial begin
    rst_n = 1'b0;
    b4.load_i = 1'b0; b4.data_i = '0; b4.dp_i = '0; b4.en_i = '0; b4.lz_en_i = 1'b0;
    repeat (3) @(negedge clk);
    check_dark("reset");
    rst_n = 1'b1;

    // Idle after reset: nothing loaded, all dark.
    repeat (30) begin
      @(negedge clk);
      check_dark("idle");
    end

    // Basic rotation with one decimal point.
    wait_point(0, 3);
    do_load(16'h1A3F, 4'hF, 4'b0010, 1'b0);
    expect_lit(4'b1101, 4'h3, 1'b0);
    expect_lit(4'b1011, 4'hA, 1'b1);
    expect_lit(4'b0111, 4'h1, 1'b1);
    expect_lit(4'b1110, 4'hF, 1'b1);

    // Leading-zero suppression.
    wait_point(0, 3);
    do_load(16'h0050, 4'hF, 4'h0, 1'b1);
    expect_lit(4'b1101, 4'h5, 1'b1);
    expect_lit(4'b1110, 4'h0, 1'b1);
    wait_point(0, 3);
    do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    expect_lit(4'b1110, 4'h0, 1'b1);

    // Load coinciding with a tick: that slot keeps the old nibble.
    wait_point(0, 3);
    do_load(16'h4321, 4'hF, 4'h0, 1'b0);
    expect_lit(4'b1101, 4'h2, 1'b1);
    expect_lit(4'b1011, 4'h3, 1'b1);
    expect_lit(4'b0111, 4'h4, 1'b1);
    expect_lit(4'b1110, 4'h1, 1'b1);
    wait_point(0, 3);
    wait_point(0, 5);
    do_load(16'h4371, 4'hF, 4'h0, 1'b0);
    expect_lit(4'b1101, 4'h2, 1'b1);
    expect_lit(4'b1011, 4'h3, 1'b1);
    expect_lit(4'b0111, 4'h4, 1'b1);
    expect_lit(4'b1110, 4'h1, 1'b1);
    expect_lit(4'b1101, 4'h7, 1'b1);
    expect_lit(4'b1011, 4'h3, 1'b1);

    // Reset while digit 2 is being driven.
    wait_point(0, 3);
    wait_point(2, 4);
    check("drive_digit2", 32'(b4.an_o), 32'b1011);
    rst_n = 1'b0;
    @(negedge clk);
    check_dark("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      check_dark("post_reset");
    end

    // Enable mask and decimal point on digit 3.
    wait_point(0, 3);
    do_load(16'h89AB, 4'b1010, 4'b1000, 1'b0);
    expect_lit(4'b1101, 4'hA, 1'b1);
    expect_lit(4'b0111, 4'h8, 1'b0);
    wait_point(0, 3);
    do_load(16'h0000, 4'h0, 4'h0, 1'b0);
    repeat (30) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    for (int k = 0; k < 1000 && !done8; k++) @(negedge clk);
    if (!done8) begin
      n_cmp++; n_err++;
      $display("FAIL d8_done: 8-digit check did not finish, got 0 expected 1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // 8-digit instance: rotation period (8 slots of 10 clocks) and 7 -> 0 wrap.
  initial begin
    int          t0;
    int          periods;
    int          pos;
    logic [7:0]  prev;
    logic [7:0]  last_lit;
    rst8_n = 1'b0;
    b8.load_i = 1'b0; b8.data_i = '0; b8.dp_i = '0; b8.en_i = '0; b8.lz_en_i = 1'b0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1;
    b8.data_i = 32'h7654_3210;
    b8.en_i   = 8'hFF;
    b8.load_i = 1'b1;
    @(negedge clk);
    b8.load_i = 1'b0;
    t0 = -1; periods = 0; prev = 8'hFF; last_lit = 8'hFF;
    for (int c = 0; c < 400 && periods < 2; c++) begin
      @(negedge clk);
      if (prev == 8'hFF && b8.an_o != 8'hFF) begin
        pos = -1;
        for (int j = 0; j < 8; j++) if (!b8.an_o[j]) pos = j;
        check("d8_hex", 32'(b8.hex_o), 32'(pos));
        if (last_lit == 8'h7F) check("d8_wrap", 32'(b8.an_o), 32'hFE);
        if (b8.an_o == 8'hFE) begin
          if (t0 >= 0) begin
            check("d8_period", 32'(c - t0), 32'd80);
            periods++;
          end
          t0 = c;
        end
        last_lit = b8.an_o;
      end
      prev = b8.an_o;
    end
    if (periods < 2) begin
      n_cmp++; n_err++;
      $display("FAIL d8_periods: got %0d measured periods, expected 2", periods);
    end
    done8 = 1'b1;
  end
endmodule
